// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction, opcode classification, a registered
// valid/ready output slot and a pending-write scoreboard that stalls fetch on RAW/WAW.
module decode_stage #(
  parameter int ADDRESS_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int OPCODE_SIZE      = 7,
  parameter int STALL_CNT_SIZE   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDRESS_SIZE-1:0]     instruction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OPCODE_SIZE-1:0]      out_opcode,
  output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] addr_r2,
  output logic [ADDRESS_SIZE-1:0]     immediate,
  output logic                        register_write,
  output logic                        illegal,
  input  logic                        wb_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] wb_addr,
  input  logic                        flush,
  output logic [STALL_CNT_SIZE-1:0]   stall_count
);

  localparam int IMM_SIZE = ADDRESS_SIZE - OPCODE_SIZE - 3 * REG_ADDRESS_SIZE;
  localparam int SB_SIZE  = 2 ** REG_ADDRESS_SIZE;
  localparam int OP_MSB   = ADDRESS_SIZE - 1;
  localparam int RD_MSB   = OP_MSB - OPCODE_SIZE;
  localparam int R1_MSB   = RD_MSB - REG_ADDRESS_SIZE;
  localparam int R2_MSB   = R1_MSB - REG_ADDRESS_SIZE;

  localparam logic [OPCODE_SIZE-1:0]      OP_NOP    = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0]      OP_ALU_R  = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0]      OP_ALU_I  = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0]      OP_LOAD   = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0]      OP_STORE  = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0]      OP_BRANCH = OPCODE_SIZE'(5);
  localparam logic [REG_ADDRESS_SIZE-1:0] REG_ZERO  = {REG_ADDRESS_SIZE{1'b0}};
  localparam logic [SB_SIZE-1:0]          SB_ZERO   = {SB_SIZE{1'b0}};
  localparam logic [SB_SIZE-1:0]          SB_ONE    = SB_SIZE'(1);
  localparam logic [STALL_CNT_SIZE-1:0]   STALL_MAX = {STALL_CNT_SIZE{1'b1}};

  // Bit 0 of the MSB-first field numbering is instruction[ADDRESS_SIZE-1].
  logic [OPCODE_SIZE-1:0]      w_opcode;
  logic [REG_ADDRESS_SIZE-1:0] w_rd, w_r1, w_r2;
  logic [IMM_SIZE-1:0]         w_imm;
  logic [ADDRESS_SIZE-1:0]     w_immediate;
  logic                        w_reg_write, w_use_r1, w_use_r2, w_illegal;
  logic                        w_hazard, w_accept, w_stall_inc;
  logic [SB_SIZE-1:0]          w_set_mask, w_clr_mask, w_busy_next;

  logic                        r_out_valid;
  logic [OPCODE_SIZE-1:0]      r_opcode;
  logic [REG_ADDRESS_SIZE-1:0] r_rd, r_r1, r_r2;
  logic [ADDRESS_SIZE-1:0]     r_immediate;
  logic                        r_reg_write, r_illegal;
  logic [SB_SIZE-1:0]          r_busy;
  logic [STALL_CNT_SIZE-1:0]   r_stall_count;

  assign w_opcode    = instruction[OP_MSB -: OPCODE_SIZE];
  assign w_rd        = instruction[RD_MSB -: REG_ADDRESS_SIZE];
  assign w_r1        = instruction[R1_MSB -: REG_ADDRESS_SIZE];
  assign w_r2        = instruction[R2_MSB -: REG_ADDRESS_SIZE];
  assign w_imm       = instruction[IMM_SIZE-1:0];
  assign w_immediate = {{(ADDRESS_SIZE - IMM_SIZE){w_imm[IMM_SIZE-1]}}, w_imm};

  // Opcode class: destination write and which sources are read.
  always_comb begin
    w_reg_write = 1'b0;
    w_use_r1    = 1'b0;
    w_use_r2    = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OP_NOP:    w_illegal = 1'b0;
      OP_ALU_R:  begin w_reg_write = 1'b1; w_use_r1 = 1'b1; w_use_r2 = 1'b1; end
      OP_ALU_I:  begin w_reg_write = 1'b1; w_use_r1 = 1'b1; end
      OP_LOAD:   begin w_reg_write = 1'b1; w_use_r1 = 1'b1; end
      OP_STORE:  begin w_use_r1 = 1'b1; w_use_r2 = 1'b1; end
      OP_BRANCH: begin w_use_r1 = 1'b1; w_use_r2 = 1'b1; end
      default:   w_illegal = 1'b1;
    endcase
  end

  // Register 0 is excluded explicitly so it can never raise a hazard.
  assign w_hazard = (w_use_r1 && (w_r1 != REG_ZERO) && r_busy[w_r1]) ||
                    (w_use_r2 && (w_r2 != REG_ZERO) && r_busy[w_r2]) ||
                    (w_reg_write && (w_rd != REG_ZERO) && r_busy[w_rd]);

  assign in_ready    = !reset && !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_stall_inc = in_valid && w_hazard && !flush;

  // Set is applied after clear so an accept beats a same-cycle writeback.
  assign w_set_mask  = (w_accept && w_reg_write && (w_rd != REG_ZERO)) ? (SB_ONE << w_rd) : SB_ZERO;
  assign w_clr_mask  = wb_valid ? (SB_ONE << wb_addr) : SB_ZERO;
  assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

  // Output slot: loads only on accept, drains when execute takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_opcode    <= {OPCODE_SIZE{1'b0}};
      r_rd        <= REG_ZERO;
      r_r1        <= REG_ZERO;
      r_r2        <= REG_ZERO;
      r_immediate <= {ADDRESS_SIZE{1'b0}};
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_opcode;
      r_rd        <= w_rd;
      r_r1        <= w_r1;
      r_r2        <= w_r2;
      r_immediate <= w_immediate;
      r_reg_write <= w_reg_write;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Pending-write scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= SB_ZERO;
    end else if (flush) begin
      r_busy <= SB_ZERO;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= {STALL_CNT_SIZE{1'b0}};
    end else if (w_stall_inc && (r_stall_count != STALL_MAX)) begin
      r_stall_count <= r_stall_count + STALL_CNT_SIZE'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_opcode     = r_opcode;
  assign addr_rd        = r_rd;
  assign addr_r1        = r_r1;
  assign addr_r2        = r_r2;
  assign immediate      = r_immediate;
  assign register_write = r_reg_write;
  assign illegal        = r_illegal;
  assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run,
// all compared against a behavioural model of decode, handshake and scoreboard.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ordy, wbv, fl;
  logic [31:0] ins;
  logic [4:0]  wba;

  logic        in_ready, out_valid, register_write, illegal;
  logic [6:0]  out_opcode;
  logic [4:0]  addr_rd, addr_r1, addr_r2;
  logic [31:0] immediate;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_busy [32];
  logic        m_ov, m_wr, m_ill;
  logic [6:0]  m_op;
  logic [4:0]  m_rd, m_r1, m_r2;
  logic [31:0] m_imm;
  logic [15:0] m_stall;

  decode_stage dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(in_ready), .instruction(ins),
    .out_valid(out_valid), .out_ready(ordy), .out_opcode(out_opcode),
    .addr_rd(addr_rd), .addr_r1(addr_r1), .addr_r2(addr_r2), .immediate(immediate),
    .register_write(register_write), .illegal(illegal), .wb_valid(wbv), .wb_addr(wba),
    .flush(fl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int op, input int rd, input int r1, input int r2, input int imm);
    return 32'((op % 128) * 33554432 + (rd % 32) * 1048576 + (r1 % 32) * 32768 + (r2 % 32) * 1024 + (imm % 1024));
  endfunction

  // {writes rd, uses r1, uses r2, illegal}
  function automatic logic [3:0] cls(input int op);
    case (op)
      0:       return 4'b0000;
      1:       return 4'b1110;
      2:       return 4'b1100;
      3:       return 4'b1100;
      4:       return 4'b0110;
      5:       return 4'b0110;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic bit model_hazard();
    int op, rd, r1, r2;
    logic [3:0] c;
    op = int'(ins / 33554432);
    rd = int'(ins / 1048576) % 32;
    r1 = int'(ins / 32768) % 32;
    r2 = int'(ins / 1024) % 32;
    c = cls(op);
    return (c[2] && r1 != 0 && m_busy[r1]) || (c[1] && r2 != 0 && m_busy[r2]) ||
           (c[3] && rd != 0 && m_busy[rd]);
  endfunction

  function automatic bit model_ready();
    return !fl && !model_hazard() && (!m_ov || ordy);
  endfunction

  function automatic logic [72:0] dut_vec();
    return {out_valid, out_opcode, addr_rd, addr_r1, addr_r2, immediate, register_write, illegal, stall_count};
  endfunction

  function automatic logic [72:0] model_vec();
    return {m_ov, m_op, m_rd, m_r1, m_r2, m_imm, m_wr, m_ill, m_stall};
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ov = 0; m_wr = 0; m_ill = 0; m_op = '0; m_rd = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_stall = '0;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit rdy, hz;
    int op, imm;
    logic [3:0] c;
    rdy = model_ready();
    hz  = model_hazard();
    @(posedge clk);
    if (fl) begin
      m_ov = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (iv && hz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (wbv) m_busy[wba] = 1'b0;
      if (iv && rdy) begin
        op = int'(ins / 33554432);
        c = cls(op);
        m_op = 7'(op);
        m_rd = 5'(ins / 1048576);
        m_r1 = 5'(ins / 32768);
        m_r2 = 5'(ins / 1024);
        imm = int'(ins % 1024);
        if (imm >= 512) imm = imm - 1024;
        m_imm = 32'(imm);
        m_wr = c[3];
        m_ill = c[0];
        m_ov = 1;
        if (c[3] && m_rd != 0) m_busy[m_rd] = 1'b1;
      end else if (ordy) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic drain();
    iv = 0; wbv = 0; fl = 1; ordy = 1;
    tick();
    fl = 0;
  endtask

  task automatic test_reset();
    rst = 1; iv = 1; ins = enc(1, 3, 1, 2, 0); ordy = 1; wbv = 0; wba = 0; fl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
    vectors++;
    if (dut_vec() !== 73'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", dut_vec()); end
    @(negedge clk);
    rst = 0; iv = 0;
  endtask

  task automatic test_alu_r();
    iv = 1; ordy = 1; ins = 32'h02308800;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL alu_r_ready: got %0b want 1", in_ready); end
    tick();
    vectors++;
    if ({out_valid, out_opcode, addr_rd, addr_r1, addr_r2, register_write, immediate} !==
        {1'b1, 7'd1, 5'd3, 5'd1, 5'd2, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL alu_r_decode: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_raw_stall();
    ins = enc(2, 4, 3, 0, 0); iv = 1; wbv = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ready: got %0b want 0", in_ready); end
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin miscompares++; $display("FAIL raw_stall_out: got %h want %h", dut_vec(), model_vec()); end
    end
    vectors++;
    if (stall_count !== 16'd3) begin miscompares++; $display("FAIL raw_stall_count: got %0d want 3", stall_count); end
    wbv = 1; wba = 3;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_no_bypass: got %0b want 0", in_ready); end
    tick();
    wbv = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL raw_release: got %0b want 1", in_ready); end
    tick();
    vectors++;
    if ({out_valid, out_opcode, addr_rd, stall_count} !== {1'b1, 7'd2, 5'd4, 16'd4}) begin
      miscompares++; $display("FAIL raw_accept: got %h want %h", dut_vec(), model_vec());
    end
    drain();
  endtask

  task automatic test_immediate();
    iv = 1; ordy = 1; ins = enc(2, 6, 7, 0, 1023);
    tick();
    vectors++;
    if (immediate !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL imm_neg: got %h want ffffffff", immediate); end
    ins = enc(2, 8, 9, 0, 5);
    tick();
    vectors++;
    if (immediate !== 32'h00000005) begin miscompares++; $display("FAIL imm_pos: got %h want 00000005", immediate); end
    drain();
  endtask

  task automatic test_back_to_back();
    iv = 1; ordy = 0; ins = enc(1, 10, 11, 12, 0);
    tick();
    ins = enc(3, 13, 11, 0, 7);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %0b want 0", in_ready); end
      tick();
      vectors++;
      if ({out_valid, out_opcode, addr_rd} !== {1'b1, 7'd1, 5'd10} || dut_vec() !== model_vec()) begin
        miscompares++; $display("FAIL bp_hold: got %h want %h", dut_vec(), model_vec());
      end
    end
    ordy = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    tick();
    vectors++;
    if ({out_valid, out_opcode, addr_rd, immediate} !== {1'b1, 7'd3, 5'd13, 32'd7}) begin
      miscompares++; $display("FAIL bp_next: got %h want %h", dut_vec(), model_vec());
    end
    drain();
  endtask

  task automatic test_illegal_r0();
    iv = 1; ordy = 1; ins = enc(127, 9, 9, 9, 0);
    tick();
    vectors++;
    if ({out_valid, illegal, register_write, out_opcode} !== {1'b1, 1'b1, 1'b0, 7'h7F}) begin
      miscompares++; $display("FAIL illegal_flags: got %h want %h", dut_vec(), model_vec());
    end
    ins = enc(1, 14, 9, 9, 0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_no_sb: got %0b want 1", in_ready); end
    tick();
    ins = enc(1, 0, 0, 0, 0);
    tick();
    ins = enc(1, 15, 0, 0, 0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL r0_reader: got %0b want 1", in_ready); end
    tick();
    vectors++;
    if (dut_vec() !== model_vec()) begin miscompares++; $display("FAIL r0_out: got %h want %h", dut_vec(), model_vec()); end
    drain();
  endtask

  task automatic test_flush();
    iv = 1; ordy = 1; ins = enc(1, 5, 1, 2, 0);
    tick();
    ins = enc(4, 0, 5, 5, 0);
    fl = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
    tick();
    fl = 0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_sb_clear: got %0b want 1", in_ready); end
    tick();
    vectors++;
    if ({out_valid, out_opcode} !== {1'b1, 7'd4}) begin miscompares++; $display("FAIL flush_accept: got %h want %h", dut_vec(), model_vec()); end
    drain();
  endtask

  task automatic test_random();
    int ops [8] = '{0, 1, 2, 3, 4, 5, 6, 127};
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      wbv  = ($urandom_range(0, 2) == 0);
      wba  = 5'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 29) == 0);
      ins  = enc(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1023));
      #1;
      vectors++;
      if (in_ready !== model_ready()) begin miscompares++; $display("FAIL rand_ready: got %0b want %0b", in_ready, model_ready()); end
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin miscompares++; $display("FAIL rand_out: got %h want %h", dut_vec(), model_vec()); end
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    iv = 1; ordy = 1; ins = enc(1, 6, 0, 0, 0);
    tick();
    ins = enc(2, 7, 6, 0, 0);
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    vectors++;
    if ({in_ready, dut_vec()} !== 74'd0) begin miscompares++; $display("FAIL reset_mid_stall: got %h want 0", {in_ready, dut_vec()}); end
    @(negedge clk);
    rst = 0; iv = 0;
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_raw_stall();
    test_immediate();
    test_back_to_back();
    test_illegal_r0();
    test_flush();
    test_random();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
